// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART RX, UART TX and TX arbiter blocks.
//   - tx_arb_state_t       : arbiter FSM state encoding (IDLE/START/WAIT/GAP)
//   - CLKS_PER_BIT_DEFAULT : default bit period in system clocks
//   - clog2 / max_int      : elaboration-time sizing helpers
// -----------------------------------------------------------------------------
package uart_pkg;

    // 100 MHz system clock at 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } tx_arb_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at ptr+1, wraps modulo
// NUM_REQ and selects the first asserted request.
//   req : request vector
//   ptr : index of the most recent winner
//   gnt : one-hot grant (all zero when no request is asserted)
//   idx : encoded index of the winner (0 when no request is asserted)
// -----------------------------------------------------------------------------
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte requesters (round-robin).
//   clk, rst    : system clock, synchronous active-high reset
//   req_valid   : per-requester byte valid, held until accepted
//   req_data    : packed bytes, requester i at [8i+7:8i]
//   req_ready   : one-hot accept, only in IDLE and never while rst is high
//   tx_start    : one-cycle start pulse to the transmitter
//   tx_data     : byte to transmit, stable from tx_start until tx_done
//   tx_done     : end-of-stop-bit pulse from the transmitter
//   grant_id    : index of the requester owning the transmitter
//   busy        : high whenever the FSM is not idle
//   err_timeout : one-cycle pulse when no tx_done arrives in time
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int GAP_CYCLES     = 0,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int IW             = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic [IW-1:0]        grant_id,
    output logic                 busy,
    output logic                 err_timeout
);

    // One counter serves both the WAIT timeout and the GAP delay.
    localparam int              CNT_MAX  = max_int(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int              CW       = max_int(1, clog2(CNT_MAX + 1));
    localparam logic [CW-1:0]   CNT_SAT  = CW'(CNT_MAX);
    localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_arb_state_t state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [IW-1:0] grant_q, grant_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        grant_d     = grant_q;
        req_ready   = '0;
        err_timeout = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rst) begin
                    req_ready = pick_gnt;
                end
                if (|pick_gnt) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_gnt[i]) begin
                            tx_data_d = req_data[8*i +: 8];
                        end
                    end
                    grant_d = pick_idx;
                    ptr_d   = pick_idx;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // A done arriving in the expiry cycle wins over the timeout.
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    err_timeout = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IW'(NUM_REQ - 1);
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
        end
    end

    assign tx_start = (state_q == ST_START);
    assign busy     = (state_q != ST_IDLE);
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Two arbiters (GAP_CYCLES=0 and GAP_CYCLES=5), each driving a behavioural
// 8N1 transmitter with CLKS_PER_BIT=4 that returns tx_done ten bit times after
// tx_start and records the byte it sent.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  v0 = '0, v5 = '0;
    logic [31:0] d0 = '0, d5 = '0;
    logic [3:0]  r0, r5;
    logic        s0, s5, busy0, busy5, e0, e5;
    logic [7:0]  td0, td5;
    logic [1:0]  g0, g5;
    logic        done0, done5;
    logic        done_m0 = 1'b0, done_f0 = 1'b0, done_m5 = 1'b0;
    logic        tx_en0 = 1'b1;

    assign done0 = done_m0 | done_f0;
    assign done5 = done_m5;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_data(d0), .req_ready(r0),
        .tx_start(s0), .tx_data(td0), .tx_done(done0), .grant_id(g0),
        .busy(busy0), .err_timeout(e0));

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(5), .TIMEOUT_CYCLES(64)) dut5 (
        .clk(clk), .rst(rst), .req_valid(v5), .req_data(d5), .req_ready(r5),
        .tx_start(s5), .tx_data(td5), .tx_done(done5), .grant_id(g5),
        .busy(busy5), .err_timeout(e5));

    // Behavioural transmitters
    logic [7:0] rx0_q[$], rx5_q[$];
    logic       m0_busy = 1'b0, m5_busy = 1'b0, stab_err0 = 1'b0, stab_err5 = 1'b0;
    int         m0_cnt = 0, m5_cnt = 0, n_start0 = 0, n_done0 = 0;
    logic [7:0] m0_byte = '0, m5_byte = '0;

    always @(posedge clk) begin
        n_start0 <= n_start0 + (s0 ? 1 : 0);
        n_done0  <= n_done0 + (done0 ? 1 : 0);
        if (rst) begin
            m0_busy <= 1'b0; done_m0 <= 1'b0;
        end else begin
            done_m0 <= 1'b0;
            if (s0 && tx_en0) begin
                m0_busy <= 1'b1; m0_cnt <= 0; m0_byte <= td0;
            end else if (m0_busy) begin
                if (td0 !== m0_byte) stab_err0 <= 1'b1;
                if (m0_cnt == FRAME - 2) begin
                    done_m0 <= 1'b1; m0_busy <= 1'b0; rx0_q.push_back(m0_byte);
                end else m0_cnt <= m0_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m5_busy <= 1'b0; done_m5 <= 1'b0;
        end else begin
            done_m5 <= 1'b0;
            if (s5) begin
                m5_busy <= 1'b1; m5_cnt <= 0; m5_byte <= td5;
            end else if (m5_busy) begin
                if (td5 !== m5_byte) stab_err5 <= 1'b1;
                if (m5_cnt == FRAME - 2) begin
                    done_m5 <= 1'b1; m5_busy <= 1'b0; rx5_q.push_back(m5_byte);
                end else m5_cnt <= m5_cnt + 1;
            end
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle0(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!busy0) return;
            step();
        end
        bound_fail(name);
    endtask

    task automatic wait_rx0(input string name, output logic [7:0] b);
        for (int i = 0; i < 200; i++) begin
            if (rx0_q.size() > 0) begin
                b = rx0_q.pop_front();
                return;
            end
            step();
        end
        b = 8'hxx;
        bound_fail(name);
    endtask

    // Reference round-robin rule: first valid index after 'last', wrapping.
    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (v[2'(c)]) return c;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [1:0] exp_grant;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t       tbl[7];
    logic [7:0] b;
    logic [7:0] pend[4][$];
    logic [7:0] expq[$];

    initial begin
        // Requester i of row r offers byte {r,i}; row 0 requester 2 offers A5.
        tbl[0] = '{4'b0100, 4'b0100, 2'd2, 8'hA5};
        tbl[1] = '{4'b0010, 4'b0010, 2'd1, 8'h11};
        tbl[2] = '{4'b1001, 4'b1000, 2'd3, 8'h23};
        tbl[3] = '{4'b1001, 4'b0001, 2'd0, 8'h30};
        tbl[4] = '{4'b1111, 4'b0010, 2'd1, 8'h41};
        tbl[5] = '{4'b0000, 4'b0000, 2'd0, 8'h00};
        tbl[6] = '{4'b0101, 4'b0100, 2'd2, 8'h62};

        // Reset with all requesters valid: nothing may be accepted.
        v0 = 4'b1111;
        d0 = 32'h13121110;
        repeat (3) step();
        chk("rst_ready", r0, 4'b0000);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_start", s0, 1'b0);
        chk("rst_data", td0, 8'h00);
        chk("rst_grant", g0, 2'd0);
        chk("rst_err", e0, 1'b0);

        // Fairness: all four continuously valid.
        rst = 1'b0;
        #1;
        chk("fair_first_ready", r0, 4'b0001);
        begin
            int ns, nd;
            bit got;
            ns = n_start0; nd = n_done0; got = 1'b0;
            for (int i = 0; i < 1000 && !got; i++) begin
                step();
                if (rx0_q.size() >= 5) begin
                    v0 = 4'b0000;
                    got = 1'b1;
                end
            end
            if (!got) bound_fail("fair_bytes");
            for (int i = 0; i < 5; i++) begin
                logic [7:0] e;
                e = 8'h10 + 8'(i % 4);
                chk($sformatf("fair_byte%0d", i), (rx0_q.size() > i) ? rx0_q[i] : 8'hxx, e);
            end
            wait_idle0("fair_idle");
            chk("fair_start_done", n_start0 - ns, n_done0 - nd);
            chk("fair_frames", n_start0 - ns, 5);
            rx0_q.delete();
        end

        // Table-driven frames.
        for (int r = 0; r < 7; r++) begin
            v0 = tbl[r].valid;
            for (int i = 0; i < 4; i++) d0[8*i +: 8] = {4'(r), 4'(i)};
            if (r == 0) d0[23:16] = 8'hA5;
            #1;
            chk($sformatf("tbl%0d_ready", r), r0, tbl[r].exp_ready);
            if (tbl[r].exp_ready == 4'b0000) begin
                repeat (3) step();
                chk($sformatf("tbl%0d_idle", r), busy0, 1'b0);
            end else begin
                step();
                v0 = 4'b0000;
                #1;
                chk($sformatf("tbl%0d_start", r), s0, 1'b1);
                chk($sformatf("tbl%0d_grant", r), g0, tbl[r].exp_grant);
                chk($sformatf("tbl%0d_txdata", r), td0, tbl[r].exp_byte);
                chk($sformatf("tbl%0d_ready_off", r), r0, 4'b0000);
                step();
                chk($sformatf("tbl%0d_start_pulse", r), s0, 1'b0);
                wait_rx0($sformatf("tbl%0d_rx", r), b);
                chk($sformatf("tbl%0d_rx", r), b, tbl[r].exp_byte);
                wait_idle0($sformatf("tbl%0d_end", r));
            end
        end

        // Timeout with the transmitter silent.
        tx_en0 = 1'b0;
        v0 = 4'b1000;
        d0 = 32'h77000000;
        #1;
        chk("to_ready", r0, 4'b1000);
        step();
        v0 = 4'b0000;
        chk("to_start", s0, 1'b1);
        begin
            int k;
            bit seen;
            seen = 1'b0;
            for (k = 1; k <= 80; k++) begin
                step();
                if (e0) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) bound_fail("to_err");
            chk("to_err_cycle", k, 64);
            step();
            chk("to_err_pulse", e0, 1'b0);
            chk("to_idle", busy0, 1'b0);
        end

        // tx_done in the expiry cycle counts as done.
        v0 = 4'b1000;
        #1;
        chk("tod_ready", r0, 4'b1000);
        step();
        v0 = 4'b0000;
        begin
            int errs;
            errs = 0;
            for (int k = 1; k < 64; k++) begin
                step();
                if (e0) errs++;
            end
            chk("tod_no_early_err", errs, 0);
        end
        step();
        done_f0 = 1'b1;
        #1;
        chk("tod_err_suppressed", e0, 1'b0);
        step();
        done_f0 = 1'b0;
        chk("tod_idle", busy0, 1'b0);

        // Next request after a timeout is served normally.
        tx_en0 = 1'b1;
        v0 = 4'b0001;
        d0 = 32'h0000005A;
        #1;
        chk("post_to_ready", r0, 4'b0001);
        step();
        v0 = 4'b0000;
        wait_rx0("post_to_rx", b);
        chk("post_to_rx", b, 8'h5A);
        wait_idle0("post_to_idle");

        // Reset in the middle of a frame.
        v0 = 4'b0010;
        d0 = 32'h0000E100;
        #1;
        chk("mid_ready", r0, 4'b0010);
        step();
        v0 = 4'b0101;
        d0 = 32'h00B200B0;
        repeat (10) step();
        rst = 1'b1;
        step();
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_data", td0, 8'h00);
        chk("mid_rst_ready", r0, 4'b0000);
        chk("mid_rst_grant", g0, 2'd0);
        rst = 1'b0;
        #1;
        chk("mid_after_ready", r0, 4'b0001);
        step();
        v0 = 4'b0000;
        wait_rx0("mid_after_rx", b);
        chk("mid_after_rx", b, 8'hB0);
        wait_idle0("mid_after_idle");
        rx0_q.delete();

        // Randomized traffic against the round-robin reference.
        begin
            int  m_ptr, cyc;
            bit  m_idle, fin;
            m_ptr = 0; m_idle = 1'b1; fin = 1'b0;
            for (int i = 0; i < 4; i++) begin
                int n;
                n = $urandom_range(0, 4);
                for (int j = 0; j < n; j++) pend[i].push_back(8'($urandom));
            end
            for (cyc = 0; cyc < 6000; cyc++) begin
                logic [3:0] vr, er;
                int w;
                if (pend[0].size() == 0 && pend[1].size() == 0 && pend[2].size() == 0 &&
                    pend[3].size() == 0 && m_idle && expq.size() == 0) begin
                    fin = 1'b1;
                    break;
                end
                step();
                for (int i = 0; i < 4; i++) begin
                    vr[i] = (pend[i].size() > 0) && ($urandom_range(0, 3) != 0);
                    d0[8*i +: 8] = (pend[i].size() > 0) ? pend[i][0] : 8'($urandom);
                end
                v0 = vr;
                #1;
                er = '0;
                w = m_idle ? rr_pick(vr, m_ptr) : -1;
                if (w >= 0) er[2'(w)] = 1'b1;
                chk("rnd_ready", r0, er);
                if (w >= 0) begin
                    m_ptr = w;
                    expq.push_back(pend[w].pop_front());
                    m_idle = 1'b0;
                end
                if (done0) begin
                    m_idle = 1'b1;
                    if (rx0_q.size() > 0 && expq.size() > 0)
                        chk("rnd_byte", rx0_q.pop_front(), expq.pop_front());
                    else
                        bound_fail("rnd_byte");
                end
            end
            v0 = 4'b0000;
            if (!fin) bound_fail("rnd_drain");
        end

        // Idle gap of 5 clocks between tx_done and the next accept.
        v5 = 4'b0011;
        d5 = 32'h0000C1C0;
        #1;
        chk("gap_ready0", r5, 4'b0001);
        step();
        v5 = 4'b0010;
        begin
            bit seen, gap_ok;
            int k;
            seen = 1'b0; gap_ok = 1'b1;
            for (int i = 0; i < 200 && !seen; i++) begin
                step();
                if (done5) seen = 1'b1;
            end
            if (!seen) bound_fail("gap_done");
            for (k = 1; k <= 20; k++) begin
                step();
                if (r5 != 4'b0000) break;
                if (!busy5) gap_ok = 1'b0;
            end
            chk("gap_accept_delay", k, 6);
            chk("gap_busy", gap_ok, 1'b1);
            chk("gap_ready1", r5, 4'b0010);
            step();
            v5 = 4'b0000;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                if (rx5_q.size() >= 2) seen = 1'b1;
                else step();
            end
            if (!seen) bound_fail("gap_rx");
            chk("gap_rx0", (rx5_q.size() > 0) ? rx5_q[0] : 8'hxx, 8'hC0);
            chk("gap_rx1", (rx5_q.size() > 1) ? rx5_q[1] : 8'hxx, 8'hC1);
        end

        chk("tx_data_stable0", stab_err0, 1'b0);
        chk("tx_data_stable5", stab_err5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, LSB-first, CLKS_PER_BIT timing) between NUM_REQ byte requesters using round-robin arbitration.
- Accepts a byte from one requester through a valid/ready handshake and issues a one-cycle start pulse with that byte to the transmitter.
- Waits for the transmitter's done pulse, then optionally inserts an idle gap before the next grant.
- Sits between the command/report producers and the UART TX datapath, mirroring the RX side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle clocks inserted after each tx_done before the next grant (0 = no gap).
- TIMEOUT_CYCLES, 64, clocks to wait for tx_done after tx_start before abandoning the frame; must exceed 10*CLKS_PER_BIT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid; held until accepted.
- req_data  in  NUM_REQ*8  packed bytes; requester i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i].
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to transmit; stable from tx_start until tx_done.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- grant_id  out  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  one-cycle pulse when TIMEOUT_CYCLES expires.

Behaviour:
- Reset values (rst high at a clk edge):
  - state=IDLE; tx_start=0; tx_data=8'h00; grant_id=0; err_timeout=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - Counters=0; req_ready=0 while rst is high.
- States: IDLE, START, WAIT, GAP.
- IDLE:
  - req_ready is combinational: the one-hot winner of the RR search, gated by state==IDLE.
  - Search starts at pointer+1, wraps modulo NUM_REQ, and picks the first i with req_valid[i]=1.
  - On accept: latch req_data[i] into tx_data, set grant_id=i, pointer=i, go to START.
  - No valid requests: stay in IDLE; req_ready is all zero.
- START: tx_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
  - Latency: accept edge to tx_start high = 1 clock.
- WAIT:
  - Counter increments every cycle.
  - tx_done=1 -> go to GAP if GAP_CYCLES>0, else IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without tx_done -> pulse err_timeout for 1 cycle, go to IDLE; the byte is dropped, not retried.
  - tx_done in the same cycle as timeout expiry -> treated as done; err_timeout is not asserted.
- GAP: count GAP_CYCLES clocks, then go to IDLE. req_ready stays 0 throughout.
- tx_done outside WAIT is ignored.
- Requester behaviour while waiting:
  - A requester dropping req_valid before accept is legal; it simply loses its turn.
  - Changing req_data while not accepted has no effect.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0,... A requester waits at most NUM_REQ-1 frames.
- Back-to-back: with GAP_CYCLES=0, the earliest next accept is in the cycle after tx_done (IDLE re-entered). Minimum spacing from tx_done to the next tx_start is 2 clocks.
- Reset mid-frame (START/WAIT/GAP): returns to IDLE next edge with all outputs at reset values. The in-flight byte is lost; the transmitter is reset by the same rst.
- Widths:
  - grant_id width is max(1, clog2(NUM_REQ)).
  - Counters are sized to the larger of GAP_CYCLES and TIMEOUT_CYCLES and saturate; they never wrap.

Decomposition:
- Shared uart_pkg:
  - State encoding constants (IDLE/START/WAIT/GAP).
  - Default CLKS_PER_BIT.
  - A clog2 function shared with the UART RX and TX modules.
- One sub-module, rr_arbiter: a combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Reusable for other shared resources.
- FSM, counters and data latch stay in uart_tx_arbiter.
- The bench instantiates uart_tx_arbiter with the team's UART transmitter and a UART_rx (CLKS_PER_BIT=4) as the checker.

Test Plan:
- Single request: req_valid[2]=1, data 8'hA5 -> req_ready=4'b0100 for 1 cycle; tx_start 1 clock later; UART_rx reports 8'hA5 with done; grant_id=2.
- All four valid continuously, data 8'h10..8'h13 -> received order 10,11,12,13,10; tx_start count equals tx_done count.
- Pointer after 1: grant to 1, then req 0 and 3 valid -> 3 granted before 0.
- GAP_CYCLES=5, two queued requests -> exactly 5 idle clocks between tx_done and the next accept; busy stays high through the gap.
- Timeout: tx_done tied to 0, TIMEOUT_CYCLES=64 -> err_timeout pulses at cycle 64 after tx_start; state returns to IDLE; next request is accepted normally.
- rst asserted in WAIT mid-byte -> next edge: busy=0, tx_data=00, req_ready=0; after release, requester 0 is served first and its byte is received intact.
